// File: rtl/manch_frame_deser.sv
// manch_frame_deser: hunts a sync word in the decoded bit stream, then deserializes length-prefixed checksummed frames into a byte FIFO (ports: i_clk, i_rst sync active-high; i_serialdata/i_bit_valid/i_sync bit input; o_data_out/o_data_valid/i_data_ready/o_data_last FIFO head; o_frame_start/o_frame_ok/o_frame_err/o_err_code status pulses; define BIT_TIMEOUT_EN to enable the TIMEOUT_CYCLES inter-bit watchdog)
module manch_frame_deser #(
  parameter int SYNC_WIDTH = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD = 16'hA55A,
  parameter int MAX_LEN = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_serialdata,
  input  logic       i_bit_valid,
  input  logic       i_sync,
  output logic [7:0] o_data_out,
  output logic       o_data_valid,
  input  logic       i_data_ready,
  output logic       o_data_last,
  output logic       o_frame_start,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;
  state_t r_state, w_state_next;
  logic [SYNC_WIDTH-2:0] r_shift;
  logic [2:0] r_bitcnt;
  logic [6:0] r_byte;
  logic [7:0] r_sum, r_rem;
  logic [8:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic [SYNC_WIDTH-1:0] w_shift_next;
  logic [7:0] w_byte;
  logic [1:0] w_code;
  logic w_acc, w_match, w_byte_done, w_pop, w_overrun, w_bad_len, w_last, w_len_done;
  logic w_timeout, w_abort, w_push, w_ok, w_err;

  assign w_acc        = i_bit_valid & i_sync;
  assign w_shift_next = {r_shift, i_serialdata};
  assign w_match      = r_state == HUNT && w_acc && w_shift_next == SYNC_WORD;
  assign w_byte       = {r_byte, i_serialdata};
  assign w_byte_done  = r_state != HUNT && w_acc && r_bitcnt == 3'd7;
  assign w_len_done   = r_state == LEN && w_byte_done;
  assign w_pop        = o_data_valid & i_data_ready;
  assign w_overrun    = r_cnt == FULL && !w_pop;
  assign w_bad_len    = w_byte == 8'd0 || w_byte > MAX_L;
  assign w_last       = r_rem == 8'd1;
  assign w_abort      = r_state != HUNT && (!i_sync || w_timeout);

`ifdef BIT_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wd;
  always_ff @(posedge i_clk)
    r_wd <= (i_rst || r_state == HUNT || w_acc) ? '0 : r_wd + 1'b1;
  assign w_timeout = r_state != HUNT && !w_acc && r_wd == WW'(TIMEOUT_CYCLES - 1);
`else
  assign w_timeout = TIMEOUT_CYCLES < 0;
`endif

  always_ff @(posedge i_clk)
    r_state <= i_rst ? HUNT : w_state_next;

  always_comb begin
    w_state_next = w_abort ? HUNT
                 : r_state == HUNT ? (w_match ? LEN : HUNT)
                 : !w_byte_done ? r_state
                 : r_state == LEN ? (w_bad_len ? HUNT : PAYLOAD)
                 : r_state == PAYLOAD ? (w_overrun ? HUNT : w_last ? CHECK : PAYLOAD)
                 : HUNT;
  end

  always_comb begin
    w_push = r_state == PAYLOAD && w_byte_done && !w_overrun;
    w_ok   = r_state == CHECK && w_byte_done && w_byte == r_sum;
    w_err  = w_abort || (w_byte_done && (r_state == LEN ? w_bad_len
                                       : r_state == PAYLOAD ? w_overrun
                                       : w_byte != r_sum));
    w_code = w_abort ? 2'd3 : r_state == LEN ? 2'd0 : r_state == PAYLOAD ? 2'd2 : 2'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift       <= '0;
      r_bitcnt      <= '0;
      r_byte        <= '0;
      r_sum         <= '0;
      r_rem         <= '0;
      r_wr          <= '0;
      r_rd          <= '0;
      r_cnt         <= '0;
      o_frame_start <= 1'b0;
      o_frame_ok    <= 1'b0;
      o_frame_err   <= 1'b0;
      o_err_code    <= 2'd0;
    end else begin
      r_shift       <= (r_state != HUNT || !i_sync || w_match) ? '0
                     : w_acc ? w_shift_next[SYNC_WIDTH-2:0] : r_shift;
      r_bitcnt      <= r_state == HUNT ? 3'd0 : r_bitcnt + 3'(w_acc);
      r_byte        <= w_acc ? w_byte[6:0] : r_byte;
      r_sum         <= w_len_done ? w_byte : w_push ? r_sum + w_byte : r_sum;
      r_rem         <= w_len_done ? w_byte : w_push ? r_rem - 8'd1 : r_rem;
      r_wr          <= r_wr + AW'(w_push);
      r_rd          <= r_rd + AW'(w_pop);
      r_cnt         <= r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
      o_frame_start <= w_match;
      o_frame_ok    <= w_ok;
      o_frame_err   <= w_err;
      o_err_code    <= w_err ? w_code : o_err_code;
    end
  end

  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= {w_last, w_byte};

  assign o_data_valid = r_cnt != '0;
  assign o_data_out   = o_data_valid ? r_mem[r_rd][7:0] : 8'd0;
  assign o_data_last  = o_data_valid & r_mem[r_rd][8];
endmodule

// File: tb/tb_manch_frame_deser.sv
// tb_manch_frame_deser: table-driven frames plus corner sequences, checked against byte/status scoreboards
module tb_manch_frame_deser;
`ifdef BIT_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif
  logic clk = 1'b0, rst = 1'b1, ser = 1'b0, bv = 1'b0, sy = 1'b1, rdy = 1'b1;
  logic [7:0] data_out;
  logic data_valid, data_last, frame_start, frame_ok, frame_err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  manch_frame_deser #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_serialdata(ser), .i_bit_valid(bv), .i_sync(sy),
    .o_data_out(data_out), .o_data_valid(data_valid), .i_data_ready(rdy),
    .o_data_last(data_last), .o_frame_start(frame_start), .o_frame_ok(frame_ok),
    .o_frame_err(frame_err), .o_err_code(err_code)
  );

  typedef struct packed {
    logic [7:0] len;
    logic [0:2][7:0] pl;
    logic [7:0] cks;
    logic ok;
    logic [1:0] code;
  } rec_t;

  rec_t tbl [8];
  rec_t t;
  logic lv;
  int n_tests = 0, n_fail = 0, n_fs = 0, n_fs_exp = 0;
  logic [8:0] exp_q [$];
  logic [2:0] st_q [$];
  logic [8:0] e;
  logic [2:0] s;
  logic [1:0] last_code = 2'd0;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser = b;
    bv = 1'b1;
    @(posedge clk); #1;
    bv = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_sync();
    n_fs_exp++;
    send_byte(8'hA5);
    send_byte(8'h5A);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || st_q.size() != 0); i++) @(posedge clk);
    #1;
    chk("bytes_delivered", exp_q.size(), 0);
    chk("status_delivered", st_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL tb_time_limit: run did not finish, required finish before 500000");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h02, {8'h12, 8'h34, 8'h00}, 8'h48, 1'b1, 2'd0};
    tbl[1] = '{8'h02, {8'h12, 8'h34, 8'h00}, 8'h49, 1'b0, 2'd1};
    tbl[2] = '{8'h02, {8'h12, 8'h34, 8'h00}, 8'h48, 1'b1, 2'd0};
    tbl[3] = '{8'h00, {8'h00, 8'h00, 8'h00}, 8'h00, 1'b0, 2'd0};
    tbl[4] = '{8'h41, {8'h00, 8'h00, 8'h00}, 8'h00, 1'b0, 2'd0};
    tbl[5] = '{8'h01, {8'hAB, 8'h00, 8'h00}, 8'hAC, 1'b1, 2'd0};
    tbl[6] = '{8'h03, {8'hFF, 8'hFF, 8'hFF}, 8'h00, 1'b1, 2'd0};
    tbl[7] = '{8'h03, {8'h01, 8'h02, 8'h03}, 8'h0A, 1'b0, 2'd1};
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (frame_start) n_fs++;
          if (frame_ok && frame_err) chk("ok_and_err_exclusive", 1, 0);
          if (data_valid && rdy) begin
            chk("byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("byte_last_data", {data_last, data_out}, e);
            end
          end
          if (frame_ok || frame_err) begin
            chk("status_expected", st_q.size() != 0, 1);
            if (st_q.size() != 0) begin
              s = st_q.pop_front();
              chk("status_ok", frame_ok, s[2]);
              chk("status_err", frame_err, !s[2]);
              if (!s[2]) last_code = s[1:0];
              chk("err_code", err_code, last_code);
            end
          end
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_data_last", data_last, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      t = tbl[r];
      lv = t.len != 8'd0 && t.len <= 8'd64;
      send_sync();
      if (!lv) st_q.push_back({1'b0, 2'd0});
      send_byte(t.len);
      if (lv) begin
        for (int i = 0; i < int'(t.len); i++) begin
          exp_q.push_back({i == int'(t.len) - 1, t.pl[i]});
          send_byte(t.pl[i]);
        end
        st_q.push_back({t.ok, t.code});
        send_byte(t.cks);
      end
      drain();
      chk("no_stray_fifo_data", data_valid, 0);
      chk("frame_start_count", n_fs, n_fs_exp);
    end
    rdy = 1'b0;
    send_sync();
    send_byte(8'h06);
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back({1'b0, 8'(k)});
      send_byte(8'(k));
    end
    st_q.push_back({1'b0, 2'd2});
    send_byte(8'h05);
    chk("overrun_valid_held", data_valid, 1);
    chk("overrun_head", data_out, 8'h01);
    chk("overrun_head_last", data_last, 0);
    rdy = 1'b1;
    drain();
    send_sync();
    send_byte(8'h02);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    st_q.push_back({1'b0, 2'd3});
    sy = 1'b0;
    @(posedge clk); #1;
    chk("lockloss_err", frame_err, 1);
    chk("lockloss_code", err_code, 3);
    repeat (3) @(posedge clk);
    #1;
    sy = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_sync();
    send_byte(8'h01);
    exp_q.push_back({1'b1, 8'hAB});
    send_byte(8'hAB);
    st_q.push_back({1'b1, 2'd0});
    send_byte(8'hAC);
    drain();
    chk("reacquire_start_count", n_fs, n_fs_exp);
    send_sync();
    for (int i = 0; i < 4; i++) send_bit(1'b0);
`ifdef BIT_TIMEOUT_EN
    st_q.push_back({1'b0, 2'd3});
    repeat (TO - 2) @(posedge clk);
    #1;
    chk("timeout_not_early", frame_err, 0);
    @(posedge clk); #1;
    chk("timeout_err", frame_err, 1);
    chk("timeout_code", err_code, 3);
    drain();
`else
    repeat (100) @(posedge clk);
    #1;
    chk("stall_no_err", frame_err, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    exp_q.push_back({1'b1, 8'hC3});
    send_byte(8'hC3);
    st_q.push_back({1'b1, 2'd0});
    send_byte(8'hC4);
    drain();
`endif
    rdy = 1'b0;
    send_sync();
    send_byte(8'h03);
    exp_q.push_back({1'b0, 8'h11});
    send_byte(8'h11);
    send_bit(1'b1);
    chk("pre_reset_valid", data_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    last_code = 2'd0;
    @(posedge clk); #1;
    chk("midrst_data_out", data_out, 0);
    chk("midrst_data_valid", data_valid, 0);
    chk("midrst_data_last", data_last, 0);
    chk("midrst_frame_start", frame_start, 0);
    chk("midrst_frame_ok", frame_ok, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_err_code", err_code, 0);
    rst = 1'b0;
    rdy = 1'b1;
    send_sync();
    send_byte(8'h01);
    exp_q.push_back({1'b1, 8'h5A});
    send_byte(8'h5A);
    st_q.push_back({1'b1, 2'd0});
    send_byte(8'h5B);
    drain();
    chk("final_start_count", n_fs, n_fs_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/manch_frame_deser.md
Name: manch_frame_deser

Overview:
Downstream stage of the Manchester decoder. Consumes the recovered bit stream (SERIALDATA plus a per-bit strobe and the decoder's SYNC lock flag), hunts for a frame sync word, then assembles length-prefixed, checksummed byte frames. Payload bytes are pushed into a small output FIFO with a valid/ready handshake; each frame ends with a pass or fail status pulse.

Parameters:
SYNC_WORD, 16'hA55A, frame sync pattern, MSB first
SYNC_WIDTH, 16, bit width of SYNC_WORD (8..32)
MAX_LEN, 64, maximum legal payload length in bytes (1..255)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 1023, inter-bit watchdog limit in CLK cycles (only with BIT_TIMEOUT_EN)

Ports:
CLK  in  1  system clock, all logic on posedge
RST  in  1  synchronous, active-high reset
SERIALDATA  in  1  decoded bit, sampled only when BIT_VALID=1
BIT_VALID  in  1  one-CLK strobe per decoded bit
SYNC  in  1  decoder lock; bits are ignored while 0
DATA_OUT  out  8  FIFO head byte
DATA_VALID  out  1  FIFO non-empty
DATA_READY  in  1  consumer accept; pop when DATA_VALID&DATA_READY
DATA_LAST  out  1  head byte is the last payload byte of its frame
FRAME_START  out  1  one-cycle pulse on sync-word match
FRAME_OK  out  1  one-cycle pulse, checksum good
FRAME_ERR  out  1  one-cycle pulse, frame failed
ERR_CODE  out  2  failure cause, valid only with FRAME_ERR: 0 bad length, 1 checksum, 2 FIFO overrun, 3 abort (lock loss/timeout)

Behaviour:
- Reset: state=HUNT; shift/bit/byte counters, checksum and FIFO pointers cleared; DATA_OUT=0, DATA_VALID=0, DATA_LAST=0, FRAME_START/OK/ERR=0, ERR_CODE=0. Reset mid-frame discards the frame and the FIFO contents, with no status pulse.
- Bit accept: a bit is accepted on a CLK edge with BIT_VALID=1 and SYNC=1. Bits shift in MSB first.
- States: HUNT, LEN, PAYLOAD, CHECK.
- HUNT: SYNC_WIDTH-bit shift register. When the register including the just-accepted bit equals SYNC_WORD, go to LEN and pulse FRAME_START on the next cycle. Overlapping matches are allowed. The shift register is cleared on leaving HUNT.
- Byte assembly: 3-bit counter; the byte completes on the 8th accepted bit and is visible internally in the same cycle.
- LEN: completed byte L. If L=0 or L>MAX_LEN, pulse FRAME_ERR with ERR_CODE=0 and go to HUNT. Otherwise checksum=L, remaining=L, go to PAYLOAD.
- PAYLOAD: each completed byte is added to the checksum (mod 256) and pushed to the FIFO, with its tag DATA_LAST=1 when remaining==1. After the last byte, go to CHECK.
- CHECK: if completed byte == checksum, pulse FRAME_OK; else pulse FRAME_ERR with ERR_CODE=1. Go to HUNT.
- Status latency: pulses occur 1 cycle after the accepting edge of the final bit.
- FIFO: stores byte plus last tag. Write-to-DATA_VALID latency is 1 cycle. If a push and a pop occur in the same cycle while full, the push is accepted. If the FIFO is full without a pop when a payload byte completes, the byte is dropped, FRAME_ERR fires with ERR_CODE=2, and the block goes to HUNT. Bytes already queued remain queued.
- Lock loss: SYNC falling while in LEN/PAYLOAD/CHECK pulses FRAME_ERR with ERR_CODE=3 and goes to HUNT. SYNC low while in HUNT clears the shift register with no pulse.
- Queued bytes of a failed frame are not retracted. The consumer qualifies data by FRAME_OK/FRAME_ERR.
- FRAME_OK and FRAME_ERR are never asserted together. At most one status pulse is issued per frame.

Optional Feature:
BIT_TIMEOUT_EN:
- Defined: a counter runs in LEN/PAYLOAD/CHECK and is cleared on each accepted bit. On reaching TIMEOUT_CYCLES, the block pulses FRAME_ERR with ERR_CODE=3 and goes to HUNT. The counter is held at 0 in HUNT.
- Undefined: no watchdog. A stalled stream holds the current state indefinitely, and the TIMEOUT_CYCLES parameter is unused.

Test Plan:
- Bits A55A, 02, 12, 34, 48 with DATA_READY=1 -> FRAME_START once; DATA_OUT 0x12 (LAST=0), then 0x34 (LAST=1); FRAME_OK pulse; ERR_CODE untouched.
- Same frame with checksum 0x49 -> both bytes delivered; FRAME_ERR with ERR_CODE=1; next valid frame gives FRAME_OK.
- Sync then LEN=0x00, and separately LEN=0x41 (MAX_LEN=64) -> FRAME_ERR with ERR_CODE=0; no FIFO push.
- DATA_READY=0, frame with LEN=6 (FIFO_DEPTH=4) -> 4 bytes queued; 5th byte gives FRAME_ERR with ERR_CODE=2; DATA_VALID stays 1 with head 1st byte.
- SYNC dropped after 3 payload bits -> FRAME_ERR with ERR_CODE=3; leading garbage bits then 0xA55A re-acquires with FRAME_START.
- BIT_TIMEOUT_EN with TIMEOUT_CYCLES=20: bits stop mid-LEN -> FRAME_ERR with ERR_CODE=3 exactly 20 cycles after the last accepted bit; RST asserted mid-PAYLOAD -> all outputs 0 next cycle.
